// File: rtl/uart_event_ctrl.sv
// Event-to-UART bridge: channel pulses become ASCII codes queued in a TX FIFO and sent 8N1,
// plus an independent 16x-oversampling 8N1 receiver.
module uart_event_ctrl #(
  parameter int         CLK_HZ     = 100_000_000,
  parameter int         BAUD       = 9600,
  parameter int         N_EVT      = 2,
  parameter logic [7:0] EVT_BASE   = 8'h41,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_EVT-1:0]              evt,
  input  logic                          rx,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          evt_drop,
  output logic [7:0]                    rx_data,
  output logic                          rx_done,
  output logic                          rx_frame_err
);
  localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [CW-1:0]    baud_cnt_q, baud_cnt_d;
  logic             tick;
  logic [N_EVT-1:0] pending_q, pending_d, clr;
  logic             drop_q, drop_d;
  logic             wr_en, pop, full, empty;
  logic [7:0]       wr_code, rd_byte;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  always_comb begin
    tick       = (baud_cnt_q == CW'(DIV - 1));
    baud_cnt_d = tick ? '0 : baud_cnt_q + CW'(1);
  end

  // Descending scan so the lowest-index pending channel wins the single write slot.
  always_comb begin
    clr     = '0;
    wr_code = EVT_BASE;
    if (!full) begin
      for (int i = N_EVT - 1; i >= 0; i--) begin
        if (pending_q[i]) begin
          clr     = '0;
          clr[i]  = 1'b1;
          wr_code = EVT_BASE + 8'(i);
        end
      end
    end
    wr_en     = |clr;
    pending_d = (pending_q & ~clr) | evt;
    drop_d    = drop_q | (|(evt & pending_q & ~clr));
  end

  always_comb begin
    full     = (level_q == LW'(FIFO_DEPTH));
    empty    = (level_q == '0);
    rd_byte  = mem_q[rd_ptr_q];
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_code;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    level_d = level_q + LW'(wr_en) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt_q <= '0;
      pending_q  <= '0;
      drop_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // TX restarts its own tick phase at every pop so each bit is exactly 16*DIV clocks.
  state_t        tx_state_q;
  logic [CW-1:0] tx_div_q;
  logic [3:0]    tx_tcnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          tx_q, tx_busy_q, tx_tick, tx_bit_end;

  always_comb begin
    pop        = (tx_state_q == IDLE) && !empty;
    tx_tick    = (tx_div_q == CW'(DIV - 1));
    tx_bit_end = tx_tick && (tx_tcnt_q == 4'd15);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= IDLE;
      tx_div_q   <= '0;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_div_q <= tx_tick ? '0 : tx_div_q + CW'(1);
      if (tx_tick) tx_tcnt_q <= tx_tcnt_q + 4'd1;
      case (tx_state_q)
        IDLE: if (pop) begin
          tx_state_q <= START;
          tx_shift_q <= rd_byte;
          tx_div_q   <= '0;
          tx_tcnt_q  <= '0;
          tx_q       <= 1'b0;
          tx_busy_q  <= 1'b1;
        end
        START: if (tx_bit_end) begin
          tx_state_q <= DATA;
          tx_bit_q   <= '0;
          tx_q       <= tx_shift_q[0];
        end
        DATA: if (tx_bit_end) begin
          if (tx_bit_q == 3'd7) begin
            tx_state_q <= STOP;
            tx_q       <= 1'b1;
          end else begin
            tx_shift_q <= tx_shift_q >> 1;
            tx_q       <= tx_shift_q[1];
            tx_bit_q   <= tx_bit_q + 3'd1;
          end
        end
        STOP: if (tx_bit_end) begin
          tx_state_q <= IDLE;
          tx_busy_q  <= 1'b0;
        end
      endcase
    end
  end

  state_t     rx_state_q;
  logic       rx_s1_q, rx_s2_q, rx_s3_q;
  logic [3:0] rx_tcnt_q;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_shift_q, rx_data_q;
  logic       rx_done_q, rx_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= IDLE;
      rx_tcnt_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_s3_q   <= rx_s2_q;
      rx_done_q <= 1'b0;
      rx_err_q  <= 1'b0;
      if (rx_state_q != IDLE && tick) rx_tcnt_q <= rx_tcnt_q + 4'd1;
      case (rx_state_q)
        IDLE: if (rx_s3_q && !rx_s2_q) begin
          rx_state_q <= START;
          rx_tcnt_q  <= '0;
        end
        START: if (tick && rx_tcnt_q == 4'd7) begin
          if (rx_s2_q) begin
            rx_state_q <= IDLE;
          end else begin
            rx_state_q <= DATA;
            rx_tcnt_q  <= '0;
            rx_bit_q   <= '0;
          end
        end
        DATA: if (tick && rx_tcnt_q == 4'd15) begin
          rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_q   <= rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_q <= STOP;
        end
        STOP: if (tick && rx_tcnt_q == 4'd15) begin
          rx_state_q <= IDLE;
          if (rx_s2_q) begin
            rx_data_q <= rx_shift_q;
            rx_done_q <= 1'b1;
          end else begin
            rx_err_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = tx_busy_q;
  assign fifo_level   = level_q;
  assign evt_drop     = drop_q;
  assign rx_data      = rx_data_q;
  assign rx_done      = rx_done_q;
  assign rx_frame_err = rx_err_q;
endmodule

// File: tb/tb_uart_event_ctrl.sv
// Bench for uart_event_ctrl: two instances (base 'S' / depth 8, base 'A' / depth 2, 8 channels)
// with serial-line scoreboards for TX frames and RX bytes.
module tb_uart_event_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] evt_a;
  logic [7:0] evt_b;
  logic       rx_a, rx_b;
  logic       tx_a, tx_busy_a, drop_a, rx_done_a, rx_err_a;
  logic       tx_b, tx_busy_b, drop_b, rx_done_b, rx_err_b;
  logic [3:0] level_a;
  logic [1:0] level_b;
  logic [7:0] rx_data_a, rx_data_b;

  int n_tests = 0;
  int n_fail  = 0;
  int rx_done_cnt = 0;
  int rx_err_cnt  = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] rxq[$];

  always #5 clk = ~clk;

  uart_event_ctrl #(.CLK_HZ(1_600_000), .BAUD(10_000), .N_EVT(2), .EVT_BASE(8'h53), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .reset(reset), .evt(evt_a), .rx(rx_a), .tx(tx_a), .tx_busy(tx_busy_a),
    .fifo_level(level_a), .evt_drop(drop_a), .rx_data(rx_data_a), .rx_done(rx_done_a),
    .rx_frame_err(rx_err_a));

  uart_event_ctrl #(.CLK_HZ(1_600_000), .BAUD(10_000), .N_EVT(8), .EVT_BASE(8'h41), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .reset(reset), .evt(evt_b), .rx(rx_b), .tx(tx_b), .tx_busy(tx_busy_b),
    .fifo_level(level_b), .evt_drop(drop_b), .rx_data(rx_data_b), .rx_done(rx_done_b),
    .rx_frame_err(rx_err_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Samples one 8N1 frame mid-bit; the caller has just seen the first low cycle of the start bit.
  task automatic get_frame(input bit which, output logic [7:0] b, output logic stp, output bit ab);
    ab = 1'b0;
    for (int k = 0; k < 80; k++) begin @(negedge clk); ab |= reset; end
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 160; k++) begin @(negedge clk); ab |= reset; end
      b[i] = which ? tx_b : tx_a;
    end
    for (int k = 0; k < 160; k++) begin @(negedge clk); ab |= reset; end
    stp = which ? tx_b : tx_a;
  endtask

  always begin : mon_a
    logic [7:0] b;
    logic       s;
    bit         ab;
    @(negedge clk);
    if (!reset && tx_a === 1'b0) begin
      get_frame(1'b0, b, s, ab);
      if (!ab) begin
        chk("a_frame_expected", q_a.size() > 0, 1);
        if (q_a.size() > 0) chk("a_byte", b, q_a.pop_front());
        chk("a_stop", s, 1);
      end
    end
  end

  always begin : mon_b
    logic [7:0] b;
    logic       s;
    bit         ab;
    @(negedge clk);
    if (!reset && tx_b === 1'b0) begin
      get_frame(1'b1, b, s, ab);
      if (!ab) begin
        chk("b_frame_expected", q_b.size() > 0, 1);
        if (q_b.size() > 0) chk("b_byte", b, q_b.pop_front());
        chk("b_stop", s, 1);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && rx_done_a === 1'b1) begin
      rx_done_cnt++;
      chk("rx_done_err_excl", rx_err_a, 0);
      chk("rx_expected", rxq.size() > 0, 1);
      if (rxq.size() > 0) chk("rx_byte", rx_data_a, rxq.pop_front());
    end
    if (!reset && rx_err_a === 1'b1) rx_err_cnt++;
  end

  task automatic send_rx(input logic [7:0] d, input logic stp);
    rx_a = 1'b0;
    repeat (160) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_a = d[i];
      repeat (160) @(negedge clk);
    end
    rx_a = stp;
    repeat (160) @(negedge clk);
    rx_a = 1'b1;
    repeat (320) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g, lvl_max, nbad;
    reset = 1'b1; evt_a = '0; evt_b = '0; rx_a = 1'b1; rx_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_a, 1);
    chk("rst_busy", tx_busy_a, 0);
    chk("rst_level", level_a, 0);
    chk("rst_drop", drop_a, 0);
    chk("rst_rx_data", rx_data_a, 0);
    chk("rst_rx_done", rx_done_a, 0);
    chk("rst_rx_err", rx_err_a, 0);
    chk("rst_level_b", level_b, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single event: latency to start bit and frame length.
    evt_a = 2'b01; q_a.push_back(8'h53);
    @(negedge clk); evt_a = '0;
    @(negedge clk);
    chk("start_not_yet", tx_a, 1);
    chk("level_one", level_a, 1);
    @(negedge clk);
    chk("start_fall", tx_a, 0);
    chk("busy_on", tx_busy_a, 1);
    n = 0;
    while (tx_busy_a && n < 3000) begin n++; @(negedge clk); end
    chk("busy_len", n, 1600);
    repeat (200) @(negedge clk);
    chk("a_drained", q_a.size(), 0);

    // Two channels in the same cycle: back-to-back frames.
    evt_b = 8'h03; q_b.push_back(8'h41); q_b.push_back(8'h42);
    @(negedge clk); evt_b = '0;
    n = 0;
    while (!tx_busy_b && n < 100) begin n++; @(negedge clk); end
    n = 0;
    while (tx_busy_b && n < 3000) begin n++; @(negedge clk); end
    chk("b2b_len1", n, 1600);
    g = 0;
    while (!tx_busy_b && g < 100) begin g++; @(negedge clk); end
    chk("b2b_gap", g, 1);
    n = 0;
    while (tx_busy_b && n < 3000) begin n++; @(negedge clk); end
    chk("b2b_len2", n, 1600);
    repeat (200) @(negedge clk);
    chk("b2b_drained", q_b.size(), 0);
    chk("b2b_drop", drop_b, 0);

    // Depth-2 FIFO saturates while five more channels wait.
    evt_b = 8'h01; q_b.push_back(8'h41);
    @(negedge clk); evt_b = '0;
    repeat (5) @(negedge clk);
    evt_b = 8'h3E;
    for (int i = 1; i <= 5; i++) q_b.push_back(8'h41 + 8'(i));
    @(negedge clk); evt_b = '0;
    lvl_max = 0; n = 0;
    while (!(q_b.size() == 0 && !tx_busy_b) && n < 12000) begin
      n++; @(negedge clk);
      if (int'(level_b) > lvl_max) lvl_max = int'(level_b);
    end
    chk("sat_level_max", lvl_max, 2);
    chk("sat_drained", q_b.size(), 0);
    chk("sat_drop", drop_b, 0);

    // Repeated pulse on a channel still pending behind a full FIFO.
    evt_b = 8'h07; q_b.push_back(8'h41); q_b.push_back(8'h42); q_b.push_back(8'h43);
    @(negedge clk); evt_b = '0;
    repeat (4) @(negedge clk);
    chk("full_level", level_b, 2);
    evt_b = 8'h08; q_b.push_back(8'h44);
    @(negedge clk); evt_b = '0;
    chk("drop_not_yet", drop_b, 0);
    repeat (2) @(negedge clk);
    evt_b = 8'h08;
    @(negedge clk); evt_b = '0;
    @(negedge clk);
    chk("drop_set", drop_b, 1);
    n = 0;
    while (!(q_b.size() == 0 && !tx_busy_b) && n < 9000) begin n++; @(negedge clk); end
    repeat (400) @(negedge clk);
    chk("drop_drained", q_b.size(), 0);
    chk("drop_sticky", drop_b, 1);

    // Receiver: good frames, bad stop bits, glitch.
    rxq.push_back(8'hA5);
    send_rx(8'hA5, 1'b1);
    chk("rx_a5_done", rx_done_cnt, 1);
    chk("rx_a5_data", rx_data_a, 8'hA5);
    chk("rx_a5_err", rx_err_cnt, 0);
    send_rx(8'hA5, 1'b0);
    chk("rx_bad1_err", rx_err_cnt, 1);
    chk("rx_bad1_done", rx_done_cnt, 1);
    send_rx(8'h3C, 1'b0);
    chk("rx_bad2_err", rx_err_cnt, 2);
    chk("rx_bad2_data", rx_data_a, 8'hA5);
    rxq.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    chk("rx_3c_data", rx_data_a, 8'h3C);
    chk("rx_3c_done", rx_done_cnt, 2);
    rx_a = 1'b0;
    repeat (50) @(negedge clk);
    rx_a = 1'b1;
    repeat (400) @(negedge clk);
    chk("glitch_done", rx_done_cnt, 2);
    chk("glitch_err", rx_err_cnt, 2);

    // Reset in the middle of data bit 3 of 8'h53 (bit 3 is 0).
    evt_a = 2'b01;
    @(negedge clk); evt_a = '0;
    n = 0;
    while (tx_a !== 1'b0 && n < 20) begin n++; @(negedge clk); end
    chk("abort_frame_started", tx_busy_a, 1);
    repeat (720) @(negedge clk);
    chk("abort_bit3_low", tx_a, 0);
    reset = 1'b1; evt_a = 2'b11;
    @(negedge clk);
    chk("abort_tx", tx_a, 1);
    chk("abort_busy", tx_busy_a, 0);
    chk("abort_level", level_a, 0);
    chk("abort_rx_data", rx_data_a, 0);
    evt_a = 2'b10;
    @(negedge clk);
    evt_a = '0;
    @(negedge clk);
    reset = 1'b0;
    nbad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || tx_busy_a !== 1'b0) nbad++;
    end
    chk("no_resume", nbad, 0);
    chk("post_level", level_a, 0);
    chk("post_drop", drop_a, 0);

    chk("final_q_a", q_a.size(), 0);
    chk("final_q_b", q_b.size(), 0);
    chk("final_rxq", rxq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
